// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter in front of the SDRAM controller command port.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_rd,
    input  logic [BE_WIDTH-1:0]   p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_write_data,
    output logic                  p0_ready,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_read_data,
    input  logic                  p1_rd,
    input  logic [BE_WIDTH-1:0]   p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_write_data,
    output logic                  p1_ready,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_read_data,
    output logic                  core_rd,
    output logic [BE_WIDTH-1:0]   core_wr,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_write_data,
    input  logic                  core_accept,
    input  logic                  core_ack,
    input  logic [DATA_WIDTH-1:0] core_read_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_owner;
    logic                  r_cmd_rd;
    logic [BE_WIDTH-1:0]   r_cmd_wr;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_grant;
    logic                  w_latch;
    logic                  w_sel_rd;
    logic [BE_WIDTH-1:0]   w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_req0 = p0_rd | (p0_wr != '0);
    assign w_req1 = p1_rd | (p1_wr != '0);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign w_grant = ~w_req0;
`else
    logic r_last;
    assign w_grant = (w_req0 & w_req1) ? ~r_last : ~w_req0;
`endif

    // A combined read+write request is forwarded as a pure read.
    assign w_sel_rd    = w_grant ? p1_rd : p0_rd;
    assign w_sel_wr    = w_sel_rd ? '0 : (w_grant ? p1_wr : p0_wr);
    assign w_sel_addr  = w_grant ? p1_addr : p0_addr;
    assign w_sel_wdata = w_grant ? p1_write_data : p0_write_data;

    always_comb begin
        w_state_next    = r_state;
        w_latch         = 1'b0;
        p0_ready        = 1'b0;
        p1_ready        = 1'b0;
        p0_ack          = 1'b0;
        p1_ack          = 1'b0;
        p0_read_data    = '0;
        p1_read_data    = '0;
        core_rd         = 1'b0;
        core_wr         = '0;
        core_addr       = '0;
        core_write_data = '0;
        unique case (r_state)
            StIdle: begin
                if ((w_req0 | w_req1) && !rst) begin
                    w_latch      = 1'b1;
                    p0_ready     = ~w_grant;
                    p1_ready     = w_grant;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                core_rd         = r_cmd_rd;
                core_wr         = r_cmd_wr;
                core_addr       = r_cmd_addr;
                core_write_data = r_cmd_wdata;
                if (core_accept) w_state_next = StWaitAck;
            end
            StWaitAck: begin
                if (core_ack && !rst) begin
                    w_state_next = StIdle;
                    if (r_owner) begin
                        p1_ack       = 1'b1;
                        p1_read_data = r_cmd_rd ? core_read_data : '0;
                    end else begin
                        p0_ack       = 1'b1;
                        p0_read_data = r_cmd_rd ? core_read_data : '0;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_cmd_rd    <= 1'b0;
            r_cmd_wr    <= '0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            r_last      <= 1'b1;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_owner     <= w_grant;
                r_cmd_rd    <= w_sel_rd;
                r_cmd_wr    <= w_sel_wr;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                r_last      <= w_grant;
`endif
            end
        end
    end

endmodule
